rop_dcr_bank: RTL and testbench

- Multi-context ROP device-configuration register bank; successor to the fixed single-set ROP DCR state.
- Holds NUM_CTX independent contexts, each with a shadow set (host-written) and an active set (read by ROP pipeline).
- Commit copies shadow to active only after that context's in-flight work has drained.
- Sits between the DCR bus and the ROP pipeline.

---
 rtl/rop_dcr_bank.sv | 221 ++++++++++++++++++++++
 tb/tb_rop_dcr_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rop_dcr_bank.sv
// ============================================================================
// Module      : rop_dcr_bank
// Description : Multi-context ROP device-configuration register bank. Each
//               context has a host-written shadow set and a pipeline-visible
//               active set. A commit copies shadow to active once that
//               context's in-flight work counter has drained to zero.
//               Optional macro ROP_DCR_READBACK_EN adds a registered
//               shadow-register readback port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rop_dcr_bank #(
    parameter int          NUM_CTX   = 2,
    parameter int          DCR_WORDS = 28,
    parameter logic [11:0] DCR_BASE  = 12'h100,
    parameter int          BUSY_BITS = 8,
    localparam int         CTX_BITS  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dcr_wr_valid,
    input  logic [11:0]               dcr_wr_addr,
    input  logic [CTX_BITS-1:0]       dcr_wr_ctx,
    input  logic [31:0]               dcr_wr_data,
    input  logic                      commit_valid,
    input  logic [CTX_BITS-1:0]       commit_ctx,
    output logic                      commit_ready,
    output logic                      commit_done,
    output logic [CTX_BITS-1:0]       commit_done_ctx,
    input  logic                      busy_inc,
    input  logic [CTX_BITS-1:0]       busy_inc_ctx,
    input  logic                      busy_dec,
    input  logic [CTX_BITS-1:0]       busy_dec_ctx,
    input  logic [CTX_BITS-1:0]       rd_ctx,
    output logic [DCR_WORDS*32-1:0]   rd_state,
    output logic [NUM_CTX-1:0]        ctx_busy,
    output logic [1:0]                err
`ifdef ROP_DCR_READBACK_EN
    ,
    input  logic                      dcr_rd_valid,
    input  logic [11:0]               dcr_rd_addr,
    input  logic [CTX_BITS-1:0]       dcr_rd_ctx,
    output logic [31:0]               dcr_rd_data,
    output logic                      dcr_rd_data_valid
`endif
);

    localparam logic [BUSY_BITS-1:0] CNT_MAX = {BUSY_BITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_COPY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [31:0]          r_shadow [NUM_CTX][DCR_WORDS];
    logic [31:0]          r_active [NUM_CTX][DCR_WORDS];
    logic [BUSY_BITS-1:0] r_cnt    [NUM_CTX];
    logic [1:0]           r_err;
    state_t               r_state;
    logic [CTX_BITS-1:0]  r_ctx;
    logic                 r_done;
    logic [CTX_BITS-1:0]  r_done_ctx;

    logic                 w_wr_in_range;
    logic [11:0]          w_wr_off;
    logic [NUM_CTX-1:0]   w_inc_hit;
    logic [NUM_CTX-1:0]   w_dec_hit;
    logic                 w_drained;

    // Address window decode for host writes
    assign w_wr_in_range = ({20'd0, dcr_wr_addr} >= 32'(DCR_BASE)) &&
                           ({20'd0, dcr_wr_addr} <  32'(DCR_BASE) + 32'(DCR_WORDS));
    assign w_wr_off      = dcr_wr_addr - DCR_BASE;

    generate
        for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx_dec
            assign w_inc_hit[i] = busy_inc && (busy_inc_ctx == CTX_BITS'(i));
            assign w_dec_hit[i] = busy_dec && (busy_dec_ctx == CTX_BITS'(i));
            assign ctx_busy[i]  = |r_cnt[i];
        end
    endgenerate

    // Host writes land in the shadow set; out-of-range address/context never matches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CTX; c++)
                for (int w = 0; w < DCR_WORDS; w++)
                    r_shadow[c][w] <= '0;
        end else if (dcr_wr_valid && w_wr_in_range) begin
            for (int c = 0; c < NUM_CTX; c++)
                for (int w = 0; w < DCR_WORDS; w++)
                    if (dcr_wr_ctx == CTX_BITS'(c) && w_wr_off == 12'(w))
                        r_shadow[c][w] <= dcr_wr_data;
        end
    end

    // Per-context in-flight counters with sticky overflow/underflow flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CTX; c++)
                r_cnt[c] <= '0;
            r_err <= '0;
        end else begin
            for (int c = 0; c < NUM_CTX; c++) begin
                if (w_inc_hit[c] && !w_dec_hit[c]) begin
                    if (r_cnt[c] == CNT_MAX)
                        r_err[0] <= 1'b1;
                    else
                        r_cnt[c] <= r_cnt[c] + BUSY_BITS'(1);
                end else if (w_dec_hit[c] && !w_inc_hit[c]) begin
                    if (r_cnt[c] == '0)
                        r_err[1] <= 1'b1;
                    else
                        r_cnt[c] <= r_cnt[c] - BUSY_BITS'(1);
                end
            end
        end
    end

    // Drain condition looks only at the registered count of the latched context
    always_comb begin
        w_drained = 1'b1;
        for (int c = 0; c < NUM_CTX; c++)
            if (r_ctx == CTX_BITS'(c) && r_cnt[c] != '0)
                w_drained = 1'b0;
    end

    // Commit sequencer: IDLE -> DRAIN -> COPY -> DONE; also owns the active set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctx      <= '0;
            r_done     <= 1'b0;
            r_done_ctx <= '0;
            for (int c = 0; c < NUM_CTX; c++)
                for (int w = 0; w < DCR_WORDS; w++)
                    r_active[c][w] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (commit_valid) begin
                        r_ctx   <= commit_ctx;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained)
                        r_state <= S_COPY;
                end
                S_COPY: begin
                    // Shadow read here is the pre-edge value, so a same-cycle write is not copied
                    for (int c = 0; c < NUM_CTX; c++)
                        if (r_ctx == CTX_BITS'(c))
                            r_active[c] <= r_shadow[c];
                    r_done     <= 1'b1;
                    r_done_ctx <= r_ctx;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational view of the selected context's active set
    always_comb begin
        rd_state = '0;
        for (int c = 0; c < NUM_CTX; c++)
            if (rd_ctx == CTX_BITS'(c))
                for (int w = 0; w < DCR_WORDS; w++)
                    rd_state[w*32 +: 32] = r_active[c][w];
    end

    assign commit_ready    = (r_state == S_IDLE);
    assign commit_done     = r_done;
    assign commit_done_ctx = r_done_ctx;
    assign err             = r_err;

`ifdef ROP_DCR_READBACK_EN
    logic        w_rd_in_range;
    logic [11:0] w_rd_off;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;

    assign w_rd_in_range = ({20'd0, dcr_rd_addr} >= 32'(DCR_BASE)) &&
                           ({20'd0, dcr_rd_addr} <  32'(DCR_BASE) + 32'(DCR_WORDS));
    assign w_rd_off      = dcr_rd_addr - DCR_BASE;

    // Registered shadow readback; returns zero for unmapped address or context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= dcr_rd_valid;
            if (dcr_rd_valid) begin
                r_rd_data <= '0;
                if (w_rd_in_range)
                    for (int c = 0; c < NUM_CTX; c++)
                        for (int w = 0; w < DCR_WORDS; w++)
                            if (dcr_rd_ctx == CTX_BITS'(c) && w_rd_off == 12'(w))
                                r_rd_data <= r_shadow[c][w];
            end
        end
    end

    assign dcr_rd_data       = r_rd_data;
    assign dcr_rd_data_valid = r_rd_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rop_dcr_bank.sv
// ============================================================================
// Module      : tb_rop_dcr_bank
// Description : Directed self-checking bench for rop_dcr_bank (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rop_dcr_bank;

    localparam int DCR_WORDS = 28;

    logic                    clk;
    logic                    reset;
    logic                    dcr_wr_valid;
    logic [11:0]             dcr_wr_addr;
    logic [0:0]              dcr_wr_ctx;
    logic [31:0]             dcr_wr_data;
    logic                    commit_valid;
    logic [0:0]              commit_ctx;
    logic                    commit_ready;
    logic                    commit_done;
    logic [0:0]              commit_done_ctx;
    logic                    busy_inc;
    logic [0:0]              busy_inc_ctx;
    logic                    busy_dec;
    logic [0:0]              busy_dec_ctx;
    logic [0:0]              rd_ctx;
    logic [DCR_WORDS*32-1:0] rd_state;
    logic [1:0]              ctx_busy;
    logic [1:0]              err;

    int n_vec  = 0;
    int n_fail = 0;

    rop_dcr_bank dut (
        .clk             (clk),
        .reset           (reset),
        .dcr_wr_valid    (dcr_wr_valid),
        .dcr_wr_addr     (dcr_wr_addr),
        .dcr_wr_ctx      (dcr_wr_ctx),
        .dcr_wr_data     (dcr_wr_data),
        .commit_valid    (commit_valid),
        .commit_ctx      (commit_ctx),
        .commit_ready    (commit_ready),
        .commit_done     (commit_done),
        .commit_done_ctx (commit_done_ctx),
        .busy_inc        (busy_inc),
        .busy_inc_ctx    (busy_inc_ctx),
        .busy_dec        (busy_dec),
        .busy_dec_ctx    (busy_dec_ctx),
        .rd_ctx          (rd_ctx),
        .rd_state        (rd_state),
        .ctx_busy        (ctx_busy),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd_word(input logic [0:0] ctx, input int w, output logic [31:0] v);
        rd_ctx = ctx;
        #1;
        v = rd_state[w*32 +: 32];
    endtask

    task automatic dcr_write(input logic [0:0] ctx, input logic [11:0] addr, input logic [31:0] data);
        dcr_wr_valid = 1'b1;
        dcr_wr_ctx   = ctx;
        dcr_wr_addr  = addr;
        dcr_wr_data  = data;
        tick();
        dcr_wr_valid = 1'b0;
    endtask

    task automatic commit_accept(input logic [0:0] ctx);
        commit_valid = 1'b1;
        commit_ctx   = ctx;
        tick();
        commit_valid = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b0; dcr_wr_valid = 1'b0; dcr_wr_addr = '0; dcr_wr_ctx = '0;
        dcr_wr_data = '0; commit_valid = 1'b0; commit_ctx = '0;
        busy_inc = 1'b0; busy_inc_ctx = '0; busy_dec = 1'b0; busy_dec_ctx = '0;
        rd_ctx = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_ready", 32'(commit_ready), 32'd1);
        check("rst_done", 32'(commit_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(ctx_busy), 32'd0);
        rd_word(1'b0, 0, v); check("rst_word0", v, 32'h0);

        // Basic write + commit on ctx0 with idle counter
        dcr_write(1'b0, 12'h100, 32'hDEADBEEF);
        commit_accept(1'b0);
        check("c0_ready_lo", 32'(commit_ready), 32'd0);
        check("c0_done_t1", 32'(commit_done), 32'd0);
        tick();
        check("c0_done_t2", 32'(commit_done), 32'd0);
        rd_word(1'b0, 0, v); check("c0_word0_pre", v, 32'h0);
        tick();
        check("c0_done_t3", 32'(commit_done), 32'd1);
        check("c0_done_ctx", 32'(commit_done_ctx), 32'd0);
        rd_word(1'b0, 0, v); check("c0_word0_post", v, 32'hDEADBEEF);
        rd_word(1'b1, 0, v); check("c1_word0_zero", v, 32'h0);
        tick();
        check("c0_done_pulse", 32'(commit_done), 32'd0);
        check("c0_ready_back", 32'(commit_ready), 32'd1);

        // Out-of-range writes, then write in the COPY cycle
        dcr_write(1'b0, 12'h0FF, 32'h11111111);
        dcr_write(1'b0, 12'h11C, 32'h22222222);
        dcr_write(1'b0, 12'h101, 32'h00000003);
        dcr_write(1'b0, 12'h11B, 32'h00000027);
        commit_accept(1'b0);
        tick();
        dcr_write(1'b0, 12'h101, 32'h00000005);
        check("cp_done", 32'(commit_done), 32'd1);
        rd_word(1'b0, 1, v);  check("cp_word1_old", v, 32'h3);
        rd_word(1'b0, 0, v);  check("oor_word0", v, 32'hDEADBEEF);
        rd_word(1'b0, 27, v); check("oor_word27", v, 32'h27);
        rd_word(1'b0, 2, v);  check("oor_word2", v, 32'h0);
        check("oor_err", 32'(err), 32'd0);
        tick();
        commit_accept(1'b0);
        tick();
        tick();
        check("cp2_done", 32'(commit_done), 32'd1);
        rd_word(1'b0, 1, v); check("cp2_word1_new", v, 32'h5);
        tick();

        // Drain hold on ctx1
        dcr_write(1'b1, 12'h102, 32'h00C0FFEE);
        busy_inc = 1'b1; busy_inc_ctx = 1'b1;
        repeat (3) tick();
        busy_inc = 1'b0;
        check("dr_busy", 32'(ctx_busy), 32'b10);
        commit_accept(1'b1);
        for (int i = 0; i < 10; i++) begin
            busy_dec     = (i == 2 || i == 5 || i == 8);
            busy_dec_ctx = 1'b1;
            tick();
            busy_dec = 1'b0;
            check($sformatf("dr_done_%0d", i), 32'(commit_done), 32'd0);
            check($sformatf("dr_ready_%0d", i), 32'(commit_ready), 32'd0);
            rd_word(1'b1, 2, v); check($sformatf("dr_word2_%0d", i), v, 32'h0);
        end
        tick();
        check("dr_done", 32'(commit_done), 32'd1);
        check("dr_done_ctx", 32'(commit_done_ctx), 32'd1);
        rd_word(1'b1, 2, v); check("dr_word2_new", v, 32'h00C0FFEE);
        check("dr_busy_clr", 32'(ctx_busy), 32'd0);
        check("dr_err", 32'(err), 32'd0);
        tick();

        // Simultaneous inc/dec at zero, then underflow
        busy_inc = 1'b1; busy_inc_ctx = 1'b0;
        busy_dec = 1'b1; busy_dec_ctx = 1'b0;
        tick();
        busy_inc = 1'b0;
        check("sim_busy", 32'(ctx_busy), 32'd0);
        check("sim_err", 32'(err), 32'd0);
        tick();
        busy_dec = 1'b0;
        check("uf_err", 32'(err), 32'b10);
        tick();
        check("uf_sticky", 32'(err), 32'b10);

        // Reset during DRAIN aborts the commit
        dcr_write(1'b0, 12'h103, 32'h00000077);
        busy_inc = 1'b1; busy_inc_ctx = 1'b0;
        tick();
        busy_inc = 1'b0;
        commit_accept(1'b0);
        tick();
        check("rd_in_drain", 32'(commit_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rd_async_err", 32'(err), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rd_ready", 32'(commit_ready), 32'd1);
        check("rd_nodone", 32'(commit_done), 32'd0);
        rd_word(1'b0, 0, v); check("rd_word0_zero", v, 32'h0);
        rd_word(1'b0, 3, v); check("rd_word3_zero", v, 32'h0);
        repeat (3) tick();
        check("rd_nodone_late", 32'(commit_done), 32'd0);

        // Overflow at counter max
        busy_inc = 1'b1; busy_inc_ctx = 1'b0;
        repeat (255) tick();
        check("of_pre_err", 32'(err), 32'd0);
        check("of_busy", 32'(ctx_busy), 32'b01);
        tick();
        busy_inc = 1'b0;
        check("of_err", 32'(err), 32'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
